// File: rtl/cache_control_pkg.sv
// Shared definitions for the cache control/status slave: register map,
// handshake states and the event-increment helper.
package cache_control_pkg;

    localparam int CTRL_ADDR_W = 4;

    localparam logic [CTRL_ADDR_W-1:0] ADDR_HIT        = 4'd0;
    localparam logic [CTRL_ADDR_W-1:0] ADDR_MISS       = 4'd1;
    localparam logic [CTRL_ADDR_W-1:0] ADDR_RD_HIT     = 4'd2;
    localparam logic [CTRL_ADDR_W-1:0] ADDR_RD_MISS    = 4'd3;
    localparam logic [CTRL_ADDR_W-1:0] ADDR_WR_HIT     = 4'd4;
    localparam logic [CTRL_ADDR_W-1:0] ADDR_WR_MISS    = 4'd5;
    localparam logic [CTRL_ADDR_W-1:0] ADDR_CNT_RST    = 4'd6;
    localparam logic [CTRL_ADDR_W-1:0] ADDR_INVALIDATE = 4'd7;
    localparam logic [CTRL_ADDR_W-1:0] ADDR_WTB_EMPTY  = 4'd8;
    localparam logic [CTRL_ADDR_W-1:0] ADDR_WTB_FULL   = 4'd9;
    localparam logic [CTRL_ADDR_W-1:0] ADDR_VERSION    = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } ctrl_state_e;

    // Combined increment of two simultaneous event pulses (0..2).
    function automatic logic [1:0] event_sum(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/cache_ctrl_counter.sv
// Saturating event counter with a 0..2 increment and synchronous clear;
// clear takes priority over any increment in the same cycle.
module cache_ctrl_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic [1:0]   inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;
    logic [W:0]   sum_s;
    logic [W-1:0] cnt_nxt_s;

    // Next value: clear, else add with saturation at all-ones.
    always_comb begin
        sum_s     = {1'b0, cnt_r} + (W + 1)'(inc);
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = {W{1'b0}};
        end else if (sum_s[W]) begin
            cnt_nxt_s = {W{1'b1}};
        end else begin
            cnt_nxt_s = sum_s[W-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/cache_control.sv
// Cache control/status slave: hit/miss counters, write-through-buffer status,
// version readback and invalidate pulse. Counters exist only with CTRL_CNT_EN.
module cache_control
    import cache_control_pkg::*;
#(
    parameter int          FE_DATA_W  = 32,
    parameter int          CTRL_CNT_W = 32,
    parameter logic [15:0] VERSION    = 16'h0001
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    input  logic [CTRL_ADDR_W-1:0] addr,
    output logic [FE_DATA_W-1:0]   rdata,
    output logic                   ready,
    input  logic                   wtbuf_empty,
    input  logic                   wtbuf_full,
    input  logic                   write_hit,
    input  logic                   write_miss,
    input  logic                   read_hit,
    input  logic                   read_miss,
    output logic                   invalidate
);

    ctrl_state_e            state_r;
    ctrl_state_e            state_nxt_s;
    logic                   accept_s;
    logic [FE_DATA_W-1:0]   rd_mux_s;
    logic [FE_DATA_W-1:0]   rdata_r;
    logic                   ready_r;
    logic                   invalidate_r;

    assign accept_s = (state_r == ST_IDLE) && valid;

`ifdef CTRL_CNT_EN
    logic                  cnt_clr_s;
    logic [CTRL_CNT_W-1:0] cnt_hit_s;
    logic [CTRL_CNT_W-1:0] cnt_miss_s;
    logic [CTRL_CNT_W-1:0] cnt_rd_hit_s;
    logic [CTRL_CNT_W-1:0] cnt_rd_miss_s;
    logic [CTRL_CNT_W-1:0] cnt_wr_hit_s;
    logic [CTRL_CNT_W-1:0] cnt_wr_miss_s;

    assign cnt_clr_s = accept_s && (addr == ADDR_CNT_RST);

    cache_ctrl_counter #(.W(CTRL_CNT_W)) u_cnt_hit (
        .clk(clk), .reset(reset), .clr(cnt_clr_s),
        .inc(event_sum(read_hit, write_hit)), .cnt(cnt_hit_s)
    );
    cache_ctrl_counter #(.W(CTRL_CNT_W)) u_cnt_miss (
        .clk(clk), .reset(reset), .clr(cnt_clr_s),
        .inc(event_sum(read_miss, write_miss)), .cnt(cnt_miss_s)
    );
    cache_ctrl_counter #(.W(CTRL_CNT_W)) u_cnt_rd_hit (
        .clk(clk), .reset(reset), .clr(cnt_clr_s),
        .inc({1'b0, read_hit}), .cnt(cnt_rd_hit_s)
    );
    cache_ctrl_counter #(.W(CTRL_CNT_W)) u_cnt_rd_miss (
        .clk(clk), .reset(reset), .clr(cnt_clr_s),
        .inc({1'b0, read_miss}), .cnt(cnt_rd_miss_s)
    );
    cache_ctrl_counter #(.W(CTRL_CNT_W)) u_cnt_wr_hit (
        .clk(clk), .reset(reset), .clr(cnt_clr_s),
        .inc({1'b0, write_hit}), .cnt(cnt_wr_hit_s)
    );
    cache_ctrl_counter #(.W(CTRL_CNT_W)) u_cnt_wr_miss (
        .clk(clk), .reset(reset), .clr(cnt_clr_s),
        .inc({1'b0, write_miss}), .cnt(cnt_wr_miss_s)
    );
`else
    logic unused_events_s;
    assign unused_events_s = ^{write_hit, write_miss, read_hit, read_miss};
`endif

    // Handshake next state: accept in IDLE, respond for exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (valid) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Read mux; sampled only at the accepting edge so same-cycle events are excluded.
    always_comb begin
        rd_mux_s = {FE_DATA_W{1'b0}};
        case (addr)
`ifdef CTRL_CNT_EN
            ADDR_HIT:       rd_mux_s = FE_DATA_W'(cnt_hit_s);
            ADDR_MISS:      rd_mux_s = FE_DATA_W'(cnt_miss_s);
            ADDR_RD_HIT:    rd_mux_s = FE_DATA_W'(cnt_rd_hit_s);
            ADDR_RD_MISS:   rd_mux_s = FE_DATA_W'(cnt_rd_miss_s);
            ADDR_WR_HIT:    rd_mux_s = FE_DATA_W'(cnt_wr_hit_s);
            ADDR_WR_MISS:   rd_mux_s = FE_DATA_W'(cnt_wr_miss_s);
`endif
            ADDR_WTB_EMPTY: rd_mux_s = FE_DATA_W'(wtbuf_empty);
            ADDR_WTB_FULL:  rd_mux_s = FE_DATA_W'(wtbuf_full);
            ADDR_VERSION:   rd_mux_s = FE_DATA_W'(VERSION);
            default:        rd_mux_s = {FE_DATA_W{1'b0}};
        endcase
    end

    // Handshake state and registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            ready_r      <= 1'b0;
            rdata_r      <= {FE_DATA_W{1'b0}};
            invalidate_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            ready_r      <= accept_s;
            rdata_r      <= accept_s ? rd_mux_s : {FE_DATA_W{1'b0}};
            invalidate_r <= accept_s && (addr == ADDR_INVALIDATE);
        end
    end

    assign ready      = ready_r;
    assign rdata      = rdata_r;
    assign invalidate = invalidate_r;

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control; counter expectations follow CTRL_CNT_EN.
module tb_cache_control;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [3:0]  addr;
    logic [31:0] rdata;
    logic        ready;
    logic        wtbuf_empty;
    logic        wtbuf_full;
    logic        write_hit;
    logic        write_miss;
    logic        read_hit;
    logic        read_miss;
    logic        invalidate;

    int total = 0;
    int bad   = 0;

    cache_control dut (
        .clk(clk), .reset(reset), .valid(valid), .addr(addr),
        .rdata(rdata), .ready(ready),
        .wtbuf_empty(wtbuf_empty), .wtbuf_full(wtbuf_full),
        .write_hit(write_hit), .write_miss(write_miss),
        .read_hit(read_hit), .read_miss(read_miss),
        .invalidate(invalidate)
    );

`ifdef CTRL_CNT_EN
    logic [31:0] rdata4;
    logic        ready4;
    logic        invalidate4;

    cache_control #(.CTRL_CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .valid(valid), .addr(addr),
        .rdata(rdata4), .ready(ready4),
        .wtbuf_empty(wtbuf_empty), .wtbuf_full(wtbuf_full),
        .write_hit(write_hit), .write_miss(write_miss),
        .read_hit(read_hit), .read_miss(read_miss),
        .invalidate(invalidate4)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic rh, input logic wh, input logic rm, input logic wm);
        read_hit = rh; write_hit = wh; read_miss = rm; write_miss = wm;
        @(negedge clk);
        read_hit = 1'b0; write_hit = 1'b0; read_miss = 1'b0; write_miss = 1'b0;
    endtask

    // Single read: ready must appear one cycle after acceptance.
    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        valid = 1'b1;
        addr  = a;
        @(negedge clk);
        check({tag, "_rdy"}, {31'd0, ready}, 32'd1);
        check(tag, rdata, exp);
        valid = 1'b0;
        @(negedge clk);
    endtask

`ifdef CTRL_CNT_EN
    task automatic rd4(input string tag, input logic [3:0] a, input logic [31:0] exp);
        valid = 1'b1;
        addr  = a;
        @(negedge clk);
        check({tag, "_rdy"}, {31'd0, ready4}, 32'd1);
        check(tag, rdata4, exp);
        valid = 1'b0;
        @(negedge clk);
    endtask
`endif

    logic [31:0] exp_cnt [6];

    initial begin
        reset = 1'b0; valid = 1'b0; addr = 4'd0;
        wtbuf_empty = 1'b1; wtbuf_full = 1'b0;
        write_hit = 1'b0; write_miss = 1'b0; read_hit = 1'b0; read_miss = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_inv", {31'd0, invalidate}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // VERSION with valid held high
        valid = 1'b1; addr = 4'd10;
        check("ver_pre", {31'd0, ready}, 32'd0);
        @(negedge clk);
        check("ver_rdy1", {31'd0, ready}, 32'd1);
        check("ver_data", rdata, 32'h0000_0001);
        @(negedge clk);
        check("ver_gap", {31'd0, ready}, 32'd0);
        check("ver_gap_d", rdata, 32'd0);
        @(negedge clk);
        check("ver_rdy2", {31'd0, ready}, 32'd1);
        valid = 1'b0;
        @(negedge clk);

        // Event accumulation
        repeat (5) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef CTRL_CNT_EN
        exp_cnt = '{32'd10, 32'd2, 32'd6, 32'd2, 32'd4, 32'd0};
`else
        exp_cnt = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
`endif
        for (int i = 0; i < 6; i++) begin
            rd($sformatf("cnt%0d", i), 4'(i), exp_cnt[i]);
        end

        // CNT_RST with a read_hit in the accepting cycle
        valid = 1'b1; addr = 4'd6; read_hit = 1'b1;
        @(negedge clk);
        read_hit = 1'b0; valid = 1'b0;
        check("crst_rdy", {31'd0, ready}, 32'd1);
        check("crst_data", rdata, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            rd($sformatf("clr%0d", i), 4'(i), 32'd0);
        end

        // INVALIDATE pulse
        valid = 1'b1; addr = 4'd7;
        check("inv_pre", {31'd0, invalidate}, 32'd0);
        @(negedge clk);
        valid = 1'b0;
        check("inv_rdy", {31'd0, ready}, 32'd1);
        check("inv_hi", {31'd0, invalidate}, 32'd1);
        check("inv_data", rdata, 32'd0);
        @(negedge clk);
        check("inv_lo", {31'd0, invalidate}, 32'd0);
        rd("rdhit_after_inv", 4'd0, 32'd0);

        // Status and unmapped addresses
        wtbuf_full = 1'b1; wtbuf_empty = 1'b0;
        rd("wtb_full1", 4'd9, 32'd1);
        rd("wtb_empty0", 4'd8, 32'd0);
        wtbuf_full = 1'b0; wtbuf_empty = 1'b1;
        rd("wtb_full0", 4'd9, 32'd0);
        rd("wtb_empty1", 4'd8, 32'd1);
        rd("unmap11", 4'd11, 32'd0);
        rd("unmap15", 4'd15, 32'd0);

        // 20 read_miss pulses
        repeat (20) pulse(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef CTRL_CNT_EN
        rd("rdmiss20", 4'd3, 32'd20);
        rd("miss20", 4'd1, 32'd20);
`else
        rd("rdmiss20", 4'd3, 32'd0);
        rd("miss20", 4'd1, 32'd0);
`endif
        rd("crst_ready", 4'd6, 32'd0);

        // Reset while responding
        valid = 1'b1; addr = 4'd7;
        @(negedge clk);
        check("mid_rdy", {31'd0, ready}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_rdy", {31'd0, ready}, 32'd0);
        check("mid_rst_inv", {31'd0, invalidate}, 32'd0);
        valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rd("post_rst_rdmiss", 4'd3, 32'd0);

`ifdef CTRL_CNT_EN
        // Saturation on the 4-bit instance
        repeat (14) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        rd4("sat_hit", 4'd0, 32'd15);
        rd4("sat_rdhit", 4'd2, 32'd15);
        rd4("sat_wrhit", 4'd4, 32'd1);
        rd("wide_hit", 4'd0, 32'd16);
        rd("wide_rdhit", 4'd2, 32'd15);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        rd4("sat_hold", 4'd0, 32'd15);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- Control/status slave for the cache.
- Sits directly downstream of the front-end's control port and consumes its ctrl_valid / ctrl_addr requests.
- Counts hit/miss events reported by the cache memory, exposes write-through-buffer status, and issues a one-cycle invalidate pulse.
- Returns read data and a one-cycle ready to the front-end, which muxes them onto the CPU bus.

Parameters:
- FE_DATA_W, 32: front-end data width; rdata width.
- CTRL_CNT_W, 32: width of each event counter; must be ≤ FE_DATA_W.
- VERSION, 16'h0001: value returned at the version address.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- valid  input  1  request from front-end ctrl_valid; held until ready.
- addr  input  `CTRL_ADDR_W  register select from front-end ctrl_addr.
- rdata  output  FE_DATA_W  read data, valid only while ready=1.
- ready  output  1  one-cycle completion strobe.
- wtbuf_empty  input  1  write-through buffer empty.
- wtbuf_full  input  1  write-through buffer full.
- write_hit  input  1  one-cycle event pulse from cache memory.
- write_miss  input  1  one-cycle event pulse from cache memory.
- read_hit  input  1  one-cycle event pulse from cache memory.
- read_miss  input  1  one-cycle event pulse from cache memory.
- invalidate  output  1  one-cycle pulse to the cache memory valid array.

Behaviour:
- Reset (reset=0, asynchronous): all counters 0, ready=0, rdata=0, invalidate=0, acceptance state IDLE.
- Address map (`CTRL_ADDR_W = 4`):
  - 0: HIT, 1: MISS, 2: RD_HIT, 3: RD_MISS, 4: WR_HIT, 5: WR_MISS.
  - 6: CNT_RST (command), 7: INVALIDATE (command).
  - 8: WTB_EMPTY, 9: WTB_FULL, 10: VERSION.
  - 11–15: read as 0.
- Handshake, two states:
  - IDLE→RESP when valid=1. In RESP: ready=1 for exactly one cycle, then back to IDLE.
  - Request accepted only in IDLE, so a held valid is served once per two cycles. Latency is always 1 cycle: valid sampled at edge N, ready high in cycle N+1.
- rdata:
  - Registered at acceptance, zero-extended to FE_DATA_W, so it reflects the value at the accepting edge (events that cycle excluded).
  - Returns 0 when ready=0.
  - Command addresses return 0.
- CNT_RST: at the accepting edge all six counters clear. A simultaneous event pulse is discarded (clear wins).
- INVALIDATE: invalidate=1 in the cycle after acceptance, coincident with ready. Counters are unaffected.
- Counters:
  - HIT increments by read_hit+write_hit; MISS by read_miss+write_miss (increment 0..2 per cycle).
  - Each specific counter increments by 1 on its pulse.
  - All counters saturate at 2^CTRL_CNT_W−1 and never wrap. An increment of 2 at max−1 yields max.
- WTB_EMPTY / WTB_FULL: bit 0 = input sampled at the accepting edge; upper bits 0.
- Event inputs are counted every cycle regardless of handshake state.
- Reset asserted mid-request: ready and invalidate drop immediately. The request is lost and the front-end re-issues it.

Optional Feature:
- CTRL_CNT_EN defined:
  - Counters and the CNT_RST command are present as described.
- CTRL_CNT_EN undefined:
  - No counter flops are built.
  - Addresses 0–5 read as 0.
  - CNT_RST is accepted (ready pulses) but has no effect.
  - Event inputs are ignored.
  - Status, version and invalidate behave identically.

Decomposition:
- `CTRL_ADDR_W` and the eleven address constants live in iob-cache.vh, shared with front_end and the software header generator.
- One natural sub-module, cache_ctrl_counter:
  - Saturating counter with 2-bit increment and synchronous clear.
  - Instantiated six times under CTRL_CNT_EN.

Test Plan:
- Reset then read VERSION (addr=10, valid held) → ready=1 exactly 1 cycle later, rdata=32'h0000_0001, valid kept high → next ready 2 cycles later.
- 5 read_hit, 3 write_hit, 2 read_miss pulses, one read_hit+write_hit cycle → HIT=10, RD_HIT=6, WR_HIT=4, MISS=2, RD_MISS=2, WR_MISS=0.
- CTRL_CNT_W=4, 14 read_hit then one read_hit+write_hit cycle → HIT=15 (saturated), RD_HIT=15, WR_HIT=1.
- Write CNT_RST with read_hit pulse in the accepting cycle → all counters 0 on next read, rdata=0 during command.
- Access INVALIDATE → invalidate high only in the ready cycle. wtbuf_full=1, read WTB_FULL → rdata=1. Reset=0 while in RESP → ready, invalidate=0 immediately.
- Build without CTRL_CNT_EN, pulse 20 read_miss, read RD_MISS → rdata=0. CNT_RST still returns ready.
